// File: rtl/ws2812_tx.sv
// WS2812 single-wire LED transmitter: serialises one 24-bit RGB word MSB first
// as fixed-period high/low pulses and handshakes with a frame sequencer.
module ws2812_tx #(
  parameter int T0H       = 20,
  parameter int T1H       = 40,
  parameter int TBIT      = 62,
  parameter int LOAD_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic [23:0] RGB,
  output logic        tx_done,
  output logic        dout
);

  localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam int LW = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;

  localparam logic [CW-1:0] CYC_LAST  = CW'(TBIT - 1);
  localparam logic [CW-1:0] HIGH_0    = CW'(T0H);
  localparam logic [CW-1:0] HIGH_1    = CW'(T1H);
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_WAIT - 1);
  localparam logic [4:0]    BIT_LAST  = 5'd23;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] load_cnt_q, load_cnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [4:0]    bit_q, bit_d;
  logic [23:0]   shift_q, shift_d;
  logic          dout_q, dout_d;
  logic          done_pulse_q, done_pulse_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    shift_d    = shift_q;

    case (state_q)
      IDLE: begin
        if (tx_en) begin
          state_d    = LOAD;
          load_cnt_d = '0;
        end
      end
      LOAD: begin
        if (load_cnt_q == LOAD_LAST) begin
          load_cnt_d = '0;
          if (tx_en) begin
            shift_d = RGB;
            bit_d   = '0;
            cyc_d   = '0;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      SEND: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      DONE: begin
        state_d    = LOAD;
        load_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // Output is decoded from next-state values so the registered dout lines up
    // with the cycle counter and bits stay back-to-back.
    dout_d       = (state_d == SEND) && (cyc_d < (shift_d[23] ? HIGH_1 : HIGH_0));
    done_pulse_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      load_cnt_q   <= '0;
      cyc_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      dout_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  // Only tx_en is combinational here, so ready drops the cycle tx_en rises.
  assign tx_done = ((state_q == IDLE) && !tx_en) || done_pulse_q;
  assign dout    = dout_q;

endmodule
